uart_rx_buffer: RTL
===================

Name: uart_rx_buffer

Overview:
- Serial receive front end that owns the CPU's `serial_in` line.
- Oversamples the line, frames 8N1 UART characters and checks start/stop bits.
- Queues received bytes in a small FIFO with a ready/valid pop interface, which the memory-mapped IO logic reads in the execute stage.
- Replaces the bare one-byte receiver so that back-to-back characters are no longer lost while the core is busy.

Parameters:
- CLOCK_FREQ, 50_000_000, core clock in Hz.
- BAUD_RATE, 115200, line rate in bits/s.
- FIFO_DEPTH, 8, byte entries; power of two, at least 2.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous active-high reset.
- serial_in  input  1  raw UART line, idle high, asynchronous to clk.
- data_out  output  8  head-of-FIFO byte; first-word-fall-through.
- data_out_valid  output  1  FIFO non-empty.
- data_out_ready  input  1  consumer pops the head when valid && ready.
- level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- frame_err  output  1  sticky: stop bit sampled low.
- overrun  output  1  sticky: byte completed while FIFO full and no pop.
- parity_err  output  1  sticky parity mismatch; tied 0 without the optional feature.
- err_clear  input  1  clears all sticky flags.

Behaviour:
- Constants:
  - BIT_TIME = CLOCK_FREQ/BAUD_RATE (integer division); 434 at defaults.
  - HALF_TIME = BIT_TIME/2.
  - Bit counter width is $clog2(BIT_TIME).
- Input path: 2-flop synchronizer, both flops reset to 1; all sampling uses the synchronized value.
- Reset (async, active-high):
  - state=WAIT_IDLE; counters 0; FIFO empty.
  - data_out_valid=0, level=0, all error flags 0.
  - data_out reads 0 while empty.
- FSM:
  - WAIT_IDLE: counts consecutive high samples; any low restarts the count; after BIT_TIME highs -> IDLE. Prevents a mid-frame reset release from being taken as a start bit.
  - IDLE: synchronized line low -> START, counter=0.
  - START: at counter==HALF_TIME-1, line low -> DATA (counter=0, bit index=0); line high -> IDLE (glitch rejected, nothing recorded).
  - DATA: sample on every counter==BIT_TIME-1; shift LSB first; after the 8th sample -> STOP (-> PARITY when the feature is on).
  - STOP: sample at counter==BIT_TIME-1.
    - High: push the byte, then IDLE.
    - Low: set frame_err, discard the byte, then WAIT_IDLE.
- Latency: data_out_valid rises the cycle after the stop-bit sample, i.e. 2 + HALF_TIME + 9*BIT_TIME cycles (±1) after the raw falling start edge.
- FIFO:
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop when valid && ready.
  - Push when not full, or when full with a pop in the same cycle; level is unchanged in that case.
  - Push when full with no pop: byte dropped, overrun set, FIFO contents unchanged.
  - Pop when empty is ignored.
- Sticky flags: err_clear clears all flags; a set event in the same cycle as err_clear wins (flag ends at 1).
- No backpressure on the line; the FSM never stalls.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1.
  - PARITY state follows DATA and samples one extra bit at BIT_TIME.
  - Even-parity mismatch sets parity_err and discards the byte; STOP is still checked.
  - Latency grows by BIT_TIME.
- Undefined:
  - No PARITY state.
  - parity_err driven constant 0.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encodings (WAIT_IDLE, IDLE, START, DATA, PARITY, STOP).
  - DATA_BITS=8.
  - The BIT_TIME/HALF_TIME derivation function.
- One sub-module: sync_fifo (DEPTH, WIDTH=8; FWFT; full/empty/level). It is reusable for the transmit side.
- Synchronizer, FSM and error flags live in uart_rx_buffer.

Test Plan:
- Reset released with line high, then frame 0xA5 -> data_out=0xA5, valid=1, level=1, frame_err=0; valid rises 2+217+9*434 cycles (±1) after the start edge.
- 100-cycle low glitch on an idle line -> no push, level=0, no flags set; FSM back in IDLE.
- Frame 0x3C with stop bit driven 0 -> no push, frame_err=1; err_clear pulse -> frame_err=0; following frame 0x11 after ≥434 high cycles -> data_out=0x11.
- Nine frames 0x01..0x09 with ready=0 -> level=8, overrun=1; popping yields 0x01..0x08 in order, and 0x09 is lost.
- FIFO full, ready=1 for exactly the cycle a tenth byte 0x0A completes -> level stays 8, overrun unchanged; tail entry is 0x0A.
- rst asserted during DATA bit 4, released while the line is still low mid-frame -> outputs reset immediately; no byte from the remainder of that frame; next clean frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings,
// character width and the bit-timing derivation used to size the counters.
package uart_pkg;

   localparam int DATA_BITS = 8;

   localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
   localparam logic [2:0] ST_IDLE      = 3'd1;
   localparam logic [2:0] ST_START     = 3'd2;
   localparam logic [2:0] ST_DATA      = 3'd3;
   localparam logic [2:0] ST_PARITY    = 3'd4;
   localparam logic [2:0] ST_STOP      = 3'd5;

   // Clock cycles per bit on the line (integer division, truncates).
   function automatic int calc_bit_time(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

   // Offset from the start edge to the centre of the start bit.
   function automatic int calc_half_time(input int clock_freq, input int baud_rate);
      return calc_bit_time(clock_freq, baud_rate) / 2;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. DEPTH must be a power of two
// so the pointers wrap naturally. A push while full is accepted only when a
// pop happens in the same cycle; otherwise it is ignored. The head reads 0
// while the FIFO is empty.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
   localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LVL_MAX);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign data    = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receiver with a byte FIFO in front of the core. Frames 8N1 by default;
// defining UART_RX_PARITY_EN switches to 8E1 with an even-parity check.
//
// state        | meaning
// WAIT_IDLE    | wait for one full bit time of continuous high before listening
// IDLE         | line idle, watching for a start edge
// START        | confirm start bit at its centre (glitch filter)
// DATA         | sample 8 data bits, LSB first, at each bit centre
// PARITY       | sample the even-parity bit (parity build only)
// STOP         | sample stop bit; push byte if high, flag framing error if low
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          serial_in,
   output logic [DATA_BITS-1:0]          data_out,
   output logic                          data_out_valid,
   input  logic                          data_out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          frame_err,
   output logic                          overrun,
   output logic                          parity_err,
   input  logic                          err_clear
);

   localparam int BIT_TIME  = calc_bit_time(CLOCK_FREQ, BAUD_RATE);
   localparam int HALF_TIME = calc_half_time(CLOCK_FREQ, BAUD_RATE);
   localparam int CW        = $clog2(BIT_TIME);

   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TIME - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_TIME - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

   logic                 sync_a;
   logic                 rx_s;
   logic [2:0]           state;
   logic [CW-1:0]        cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 bit_end;
   logic                 half_end;
   logic                 push_req;
   logic                 frame_set;
   logic                 overrun_set;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 par_bad;
   logic                 parity_set;

   assign bit_end  = (cnt == BIT_LAST);
   assign half_end = (cnt == HALF_LAST);

   // Two-flop synchronizer; resets to the idle (high) level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         sync_a <= serial_in;
         rx_s   <= sync_a;
      end
   end

   // Receive state machine; the bit counter doubles as the idle-qualify timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_WAIT_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         case (state)
            ST_WAIT_IDLE: begin
               if (!rx_s) begin
                  cnt <= '0;
               end else if (bit_end) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            ST_IDLE: begin
               if (!rx_s) begin
                  cnt   <= '0;
                  state <= ST_START;
               end
            end
            ST_START: begin
               if (half_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  cnt     <= '0;
                  shift   <= {rx_s, shift[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (bit_end) begin
                  cnt   <= '0;
                  state <= ST_STOP;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
`endif
            ST_STOP: begin
               if (bit_end) begin
                  cnt   <= '0;
                  state <= rx_s ? ST_IDLE : ST_WAIT_IDLE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               cnt   <= '0;
               state <= ST_WAIT_IDLE;
            end
         endcase
      end
   end

`ifdef UART_RX_PARITY_EN
   assign parity_set = (state == ST_PARITY) && bit_end && ((^shift) != rx_s);

   // Remembers a parity mismatch until the stop bit decides the byte's fate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    par_bad <= 1'b0;
      else if (state == ST_START) par_bad <= 1'b0;
      else if (parity_set)        par_bad <= 1'b1;
   end

   // Sticky parity error flag; a new mismatch beats a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             parity_err <= 1'b0;
      else if (parity_set) parity_err <= 1'b1;
      else if (err_clear)  parity_err <= 1'b0;
   end
`else
   assign par_bad    = 1'b0;
   assign parity_set = 1'b0;
   assign parity_err = 1'b0;
`endif

   // Stop-bit outcome, decoded in the sampling cycle so the FIFO writes on that edge.
   always_comb begin
      push_req    = 1'b0;
      frame_set   = 1'b0;
      if ((state == ST_STOP) && bit_end) begin
         push_req  = rx_s && !par_bad;
         frame_set = !rx_s;
      end
      overrun_set = push_req && fifo_full && !data_out_ready;
   end

   // Sticky frame/overrun flags; a set event beats a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (frame_set)      frame_err <= 1'b1;
         else if (err_clear) frame_err <= 1'b0;
         if (overrun_set)    overrun   <= 1'b1;
         else if (err_clear) overrun   <= 1'b0;
      end
   end

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_req),
      .push_data (shift),
      .pop       (data_out_ready),
      .data      (data_out),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .level     (level)
   );

   assign data_out_valid = !fifo_empty;

endmodule
